// File: rtl/or16_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// or16_arbiter_pkg
// Shared definitions for the two-requester OR arbiter:
//   - datapath width
//   - FSM state encoding (IDLE = 0, HOLD = 1)
//   - requester ID constants
//   - operand pair struct and a small helper for round-robin priority
// -----------------------------------------------------------------------------
package or16_arbiter_pkg;

  localparam int DATA_W = 16;

  // Requester identifiers; also the encoding of grant_id and of the priority
  // register.
  localparam logic REQ_ID_0 = 1'b0;
  localparam logic REQ_ID_1 = 1'b1;

  typedef enum logic {
    ST_IDLE = 1'b0,  // no result held
    ST_HOLD = 1'b1   // result held for the owner in grant_id
  } state_e;

  typedef struct packed {
    logic [DATA_W-1:0] a;
    logic [DATA_W-1:0] b;
  } operands_t;

  // The requester that did not win; receives priority after an acceptance.
  function automatic logic other_id(input logic id);
    return (id == REQ_ID_0) ? REQ_ID_1 : REQ_ID_0;
  endfunction

endpackage : or16_arbiter_pkg

// File: rtl/or16.sv
// -----------------------------------------------------------------------------
// or16
// Gate-level 16-bit bitwise OR. One OR primitive per bit, no behavioural
// operator, so the datapath netlist is fixed regardless of synthesis flow.
//
// Ports:
//   i_a  [15:0] in   operand a
//   i_b  [15:0] in   operand b
//   o_y  [15:0] out  i_a | i_b, bit by bit
// -----------------------------------------------------------------------------
module or16 (
  input  logic [15:0] i_a,
  input  logic [15:0] i_b,
  output wire  [15:0] o_y
);

  for (genvar g = 0; g < 16; g++) begin : g_bit
    or u_or (o_y[g], i_a[g], i_b[g]);
  end

endmodule : or16

// File: rtl/or16_arbiter.sv
// -----------------------------------------------------------------------------
// or16_arbiter
// Two requesters share one registered 16-bit OR unit. A round-robin arbiter
// picks one requester per cycle; the result is held (HOLD) until its owner
// acknowledges it. When the acknowledge and a new acceptance coincide, the new
// result is loaded in the same cycle, giving one operation per cycle.
//
// Parameters:
//   INIT_PRIO          requester (0/1) that holds priority after reset
//
// Ports:
//   clk                in   clock, rising edge
//   rst_n              in   asynchronous active-low reset
//   req_valid_0/1      in   requester presents an operation
//   req_ready_0/1      out  operation accepted when valid & ready at clk edge
//   req_a_0/1,req_b_0/1 in  16-bit operands, sampled on acceptance only
//   rsp_valid_0/1      out  result available for requester 0/1
//   rsp_ready_0/1      in   requester consumes the result
//   rsp_data     [15:0] out shared result, qualified by rsp_valid_x
//   busy               out  high while a result is held
//   grant_id           out  owner of the held result
// -----------------------------------------------------------------------------
module or16_arbiter
  import or16_arbiter_pkg::*;
#(
  parameter logic INIT_PRIO = REQ_ID_0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid_0,
  input  logic              req_valid_1,
  output logic              req_ready_0,
  output logic              req_ready_1,
  input  logic [DATA_W-1:0] req_a_0,
  input  logic [DATA_W-1:0] req_b_0,
  input  logic [DATA_W-1:0] req_a_1,
  input  logic [DATA_W-1:0] req_b_1,
  output logic              rsp_valid_0,
  output logic              rsp_valid_1,
  input  logic              rsp_ready_0,
  input  logic              rsp_ready_1,
  output logic [DATA_W-1:0] rsp_data,
  output logic              busy,
  output logic              grant_id
);

  state_e            r_state;
  state_e            w_state_next;
  logic              r_grant_id;
  logic              r_prio;
  logic [DATA_W-1:0] r_rsp_data;

  logic              w_sel;
  logic              w_rsp_hs;
  logic              w_can_accept;
  logic              w_accept;
  operands_t         w_ops;
  logic [DATA_W-1:0] w_or_y;

  // ---------------------------------------------------------------------------
  // Arbitration: a lone requester wins outright; on contention the priority
  // holder wins.
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in an always_comb gets a default on the first
  // line, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    w_sel = r_prio;
    if (req_valid_0 && !req_valid_1) begin
      w_sel = REQ_ID_0;
    end else if (req_valid_1 && !req_valid_0) begin
      w_sel = REQ_ID_1;
    end
  end

  // Owner acknowledge; the non-owner's rsp_ready is ignored, and so is
  // everything in IDLE.
  assign w_rsp_hs = (r_state == ST_HOLD) &&
                    ((r_grant_id == REQ_ID_0) ? rsp_ready_0 : rsp_ready_1);

  // A slot is free in IDLE, or in HOLD when the held result leaves this cycle.
  // Gating with rst_n keeps both readies low throughout reset.
  assign w_can_accept = rst_n && ((r_state == ST_IDLE) || w_rsp_hs);

  assign req_ready_0 = w_can_accept && req_valid_0 && (w_sel == REQ_ID_0);
  assign req_ready_1 = w_can_accept && req_valid_1 && (w_sel == REQ_ID_1);

  // Each ready already implies its valid, so this is the acceptance.
  assign w_accept = req_ready_0 || req_ready_1;

  // ---------------------------------------------------------------------------
  // Datapath: operand mux into the gate-level OR unit.
  // ---------------------------------------------------------------------------
  always_comb begin
    w_ops = '{a: req_a_0, b: req_b_0};
    if (w_sel == REQ_ID_1) begin
      w_ops = '{a: req_a_1, b: req_b_1};
    end
  end

  or16 u_or16 (
    .i_a (w_ops.a),
    .i_b (w_ops.b),
    .o_y (w_or_y)
  );

  // ---------------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          w_state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        // Handshake with a new acceptance stays in HOLD (back-to-back).
        if (w_rsp_hs && !w_accept) begin
          w_state_next = ST_IDLE;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // values from before the edge, independent of process evaluation order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Result, owner and priority only move on an acceptance; while a result is
  // held without acceptance they stay frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp_data <= '0;
      r_grant_id <= REQ_ID_0;
      r_prio     <= INIT_PRIO;
    end else if (w_accept) begin
      r_rsp_data <= w_or_y;
      r_grant_id <= w_sel;
      r_prio     <= other_id(w_sel);
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs: response valids decode from state and owner, so at most one is
  // ever high.
  // ---------------------------------------------------------------------------
  assign rsp_valid_0 = (r_state == ST_HOLD) && (r_grant_id == REQ_ID_0);
  assign rsp_valid_1 = (r_state == ST_HOLD) && (r_grant_id == REQ_ID_1);
  assign busy        = (r_state == ST_HOLD);
  assign grant_id    = r_grant_id;
  assign rsp_data    = r_rsp_data;

endmodule : or16_arbiter

// File: tb/tb_or16_arbiter.sv
// -----------------------------------------------------------------------------
// tb_or16_arbiter
// Directed self-checking bench for or16_arbiter (INIT_PRIO = 0). Inputs change
// 1 ns after a rising edge; outputs are compared 1 ns after that.
// -----------------------------------------------------------------------------
module tb_or16_arbiter;

  logic        clk;
  logic        rst_n;
  logic        req_valid_0, req_valid_1;
  logic        req_ready_0, req_ready_1;
  logic [15:0] req_a_0, req_b_0, req_a_1, req_b_1;
  logic        rsp_valid_0, rsp_valid_1;
  logic        rsp_ready_0, rsp_ready_1;
  logic [15:0] rsp_data;
  logic        busy;
  logic        grant_id;

  int n_assert = 0;
  int n_fail   = 0;

  or16_arbiter #(.INIT_PRIO(1'b0)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid_0 (req_valid_0),
    .req_valid_1 (req_valid_1),
    .req_ready_0 (req_ready_0),
    .req_ready_1 (req_ready_1),
    .req_a_0     (req_a_0),
    .req_b_0     (req_b_0),
    .req_a_1     (req_a_1),
    .req_b_1     (req_b_1),
    .rsp_valid_0 (rsp_valid_0),
    .rsp_valid_1 (rsp_valid_1),
    .rsp_ready_0 (rsp_ready_0),
    .rsp_ready_1 (rsp_ready_1),
    .rsp_data    (rsp_data),
    .busy        (busy),
    .grant_id    (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full output snapshot against expected values.
  task automatic check_out(input string tag, input logic rv0, input logic rv1,
                           input logic [15:0] data, input logic bsy, input logic gid);
    check({tag, ".rsp_valid_0"}, {15'd0, rsp_valid_0}, {15'd0, rv0});
    check({tag, ".rsp_valid_1"}, {15'd0, rsp_valid_1}, {15'd0, rv1});
    check({tag, ".rsp_data"},    rsp_data,             data);
    check({tag, ".busy"},        {15'd0, busy},        {15'd0, bsy});
    check({tag, ".grant_id"},    {15'd0, grant_id},    {15'd0, gid});
  endtask

  task automatic check_rdy(input string tag, input logic r0, input logic r1);
    check({tag, ".req_ready_0"}, {15'd0, req_ready_0}, {15'd0, r0});
    check({tag, ".req_ready_1"}, {15'd0, req_ready_1}, {15'd0, r1});
  endtask

  logic [15:0] b2b_a   [4] = '{16'h0011, 16'h0220, 16'h3300, 16'h4004};
  logic [15:0] b2b_b   [4] = '{16'h0100, 16'h0002, 16'h0030, 16'h8000};
  logic [15:0] b2b_exp [4] = '{16'h0111, 16'h0222, 16'h3330, 16'hC004};

  initial begin
    // ---- reset state, with both requests asserted -------------------------
    rst_n       = 1'b0;
    req_valid_0 = 1'b1;
    req_valid_1 = 1'b1;
    req_a_0 = '0; req_b_0 = '0; req_a_1 = '0; req_b_1 = '0;
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;
    #1;
    check_out("reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_rdy("reset", 1'b0, 1'b0);
    tick();
    tick();
    check_rdy("reset_held", 1'b0, 1'b0);
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rst_n = 1'b1;

    // ---- single request ---------------------------------------------------
    tick();
    req_valid_0 = 1'b1; req_a_0 = 16'h00F0; req_b_0 = 16'h0F00;
    #1;
    check_rdy("single", 1'b1, 1'b0);
    tick();
    req_valid_0 = 1'b0;
    check_out("single_rsp", 1'b1, 1'b0, 16'h0FF0, 1'b1, 1'b0);
    rsp_ready_0 = 1'b1;
    tick();
    rsp_ready_0 = 1'b0;
    check_out("single_idle", 1'b0, 1'b0, 16'h0FF0, 1'b0, 1'b0);

    // ---- backpressure: priority is 1 now, lone req_0 still wins -----------
    req_valid_0 = 1'b1; req_a_0 = 16'h1234; req_b_0 = 16'h4321;
    #1;
    check_rdy("bp_accept", 1'b1, 1'b0);
    tick();
    req_valid_1 = 1'b1; req_a_1 = 16'h00FF; req_b_1 = 16'hFF00;
    for (int i = 0; i < 5; i++) begin
      #1;
      check_out("bp_hold", 1'b1, 1'b0, 16'h5335, 1'b1, 1'b0);
      check_rdy("bp_hold", 1'b0, 1'b0);
      tick();
    end
    // Acknowledge with both valid: priority holder (1) takes the slot.
    rsp_ready_0 = 1'b1;
    #1;
    check_rdy("bp_release", 1'b0, 1'b1);
    tick();
    check_out("bp_b2b", 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);

    // ---- wrong-owner acknowledge -----------------------------------------
    req_valid_0 = 1'b0;
    req_valid_1 = 1'b0;
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check_out("wrong_owner", 1'b0, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    end
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b1;
    tick();
    check_out("owner_ack", 1'b0, 1'b0, 16'hFFFF, 1'b0, 1'b1);

    // ---- simultaneous requests after reset --------------------------------
    rst_n = 1'b0;
    #1;
    check_out("sim_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    rsp_ready_0 = 1'b1;
    rsp_ready_1 = 1'b1;
    req_valid_0 = 1'b1; req_a_0 = 16'h0001; req_b_0 = 16'h0002;
    req_valid_1 = 1'b1; req_a_1 = 16'h8000; req_b_1 = 16'h0000;
    #1;
    check_rdy("sim_first", 1'b1, 1'b0);
    tick();
    check_out("sim_rsp0", 1'b1, 1'b0, 16'h0003, 1'b1, 1'b0);
    req_valid_0 = 1'b0;
    #1;
    check_rdy("sim_second", 1'b0, 1'b1);
    tick();
    check_out("sim_rsp1", 1'b0, 1'b1, 16'h8000, 1'b1, 1'b1);
    req_valid_1 = 1'b0;
    tick();
    check_out("sim_idle", 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);

    // ---- back-to-back throughput on requester 1 ---------------------------
    req_valid_1 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      req_a_1 = b2b_a[k];
      req_b_1 = b2b_b[k];
      #1;
      check_rdy("b2b_rdy", 1'b0, 1'b1);
      tick();
      check_out("b2b_rsp", 1'b0, 1'b1, b2b_exp[k], 1'b1, 1'b1);
    end
    req_valid_1 = 1'b0;
    tick();
    check_out("b2b_idle", 1'b0, 1'b0, 16'hC004, 1'b0, 1'b1);
    rsp_ready_0 = 1'b0;
    rsp_ready_1 = 1'b0;

    // ---- mid-operation reset (priority is 1 before it) --------------------
    req_valid_0 = 1'b1; req_a_0 = 16'hAAAA; req_b_0 = 16'h5555;
    tick();
    check_out("mid_hold", 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0);
    req_valid_1 = 1'b1; req_a_1 = 16'h0F0F; req_b_1 = 16'h0000;
    req_a_0 = 16'h0C00; req_b_0 = 16'h0030;
    #2;
    rst_n = 1'b0;
    #1;
    check_out("mid_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    check_rdy("mid_reset", 1'b0, 1'b0);
    tick();
    check_out("mid_reset_held", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    rst_n = 1'b1;
    #1;
    check_rdy("post_reset", 1'b1, 1'b0);
    check_out("post_reset", 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0);
    tick();
    check_out("post_reset_rsp", 1'b1, 1'b0, 16'h0C30, 1'b1, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule : tb_or16_arbiter

// File: doc/or16_arbiter.md
OR16_ARBITER -- requirements
Module: or16_arbiter

Interface
REQ-001 SHALL have parameter INIT_PRIO, default 0, meaning the requester (0 or 1) that holds round-robin priority after reset.
REQ-002 SHALL have port clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-004 SHALL have ports req_valid_0 / req_valid_1, input, 1 bit each: requester 0/1 presents an operation.
REQ-005 SHALL have ports req_ready_0 / req_ready_1, output, 1 bit each: operation accepted when valid and ready are both high at a clk edge.
REQ-006 SHALL have ports req_a_0, req_b_0, req_a_1, req_b_1, input, 16 bits each: operands, sampled only on acceptance.
REQ-007 SHALL have ports rsp_valid_0 / rsp_valid_1, output, 1 bit each: result available for requester 0/1.
REQ-008 SHALL have ports rsp_ready_0 / rsp_ready_1, input, 1 bit each: requester consumes the result.
REQ-009 SHALL have port rsp_data, output, 16 bits: result shared by both requesters, qualified by rsp_valid_x.
REQ-010 SHALL have port busy, output, 1 bit: high while a result is held.
REQ-011 SHALL have port grant_id, output, 1 bit: owner of the held result.

Function
REQ-012 SHALL implement two states: IDLE (no result held) and HOLD (result held).
REQ-013 SHALL compute rsp_data = a | b bitwise, with a and b being the operands of the accepted requester, registered; latency is exactly 1 cycle from acceptance to rsp_valid_x high.
REQ-014 SHALL, when only one req_valid is high, grant that requester; when both are high, grant the requester holding priority.
REQ-015 SHALL pass priority to the non-granted requester after every acceptance; priority SHALL remain unchanged on cycles with no acceptance.
REQ-016 SHALL drive req_ready_x high only for the requester that would be granted in the current cycle, and only when state is IDLE or a response handshake completes in the same cycle; req_ready_x SHALL depend combinationally on req_valid_x, rsp_ready_x and state, not on operand values.
REQ-017 SHALL, in IDLE with an acceptance, transition to HOLD and load rsp_data, grant_id and rsp_valid_{grant}.
REQ-018 SHALL, in HOLD, keep rsp_data, grant_id and rsp_valid stable until rsp_ready_{grant_id} is high.
REQ-019 SHALL, in HOLD with a response handshake and a new acceptance in the same cycle, remain in HOLD with the new result loaded (back-to-back, one op per cycle).
REQ-020 SHALL, in HOLD with a response handshake and no acceptance, return to IDLE and clear rsp_valid.
REQ-021 SHALL ignore rsp_ready of the non-owning requester, and rsp_ready of either requester while in IDLE.
REQ-022 SHALL never assert rsp_valid_0 and rsp_valid_1 simultaneously, nor req_ready_0 and req_ready_1 simultaneously.
REQ-023 SHALL drive busy high exactly when state is HOLD.

Reset
REQ-024 SHALL, on rst_n low, immediately and asynchronously enter IDLE: rsp_valid_0/1 = 0, busy = 0, rsp_data = 16'h0000, grant_id = 0, priority = INIT_PRIO.
REQ-025 SHALL drop any held result when reset is asserted mid-operation; no result is delivered after reset release.
REQ-026 SHALL hold req_ready_0/1 low while rst_n is low.

Structure
REQ-027 SHALL take state encodings (IDLE = 0, HOLD = 1) and the requester ID constants from a shared project header, not from local literals.
REQ-028 SHALL instantiate the existing or16 gate-level module as its single datapath sub-module, fed by the operand mux; no behavioural OR operator on the datapath.

Verification
REQ-029 SHALL be verified with a single request: req_0 a=16'h00F0, b=16'h0F00 -> req_ready_0 high, next cycle rsp_valid_0=1, rsp_data=16'h0FF0, busy=1.
REQ-030 SHALL be verified with simultaneous requests after reset (INIT_PRIO=0), both rsp_ready tied high: req_0 (16'h0001|16'h0002) and req_1 (16'h8000|16'h0000) -> req_0 granted first with 16'h0003, req_1 granted the next cycle with 16'h8000, grant_id 0 then 1.
REQ-031 SHALL be verified with backpressure: rsp_ready_0 low for 5 cycles after a req_0 acceptance -> rsp_data and rsp_valid_0 stable, req_ready_0/1 low throughout, state HOLD.
REQ-032 SHALL be verified for back-to-back throughput: req_1 valid continuously and rsp_ready_1 high, 4 operations -> 4 results on 4 consecutive cycles, busy continuously high.
REQ-033 SHALL be verified with a mid-operation reset: rst_n pulled low while in HOLD -> rsp_valid_0/1 = 0 and rsp_data = 16'h0000 without waiting for a clk edge; after release the first grant with both requests valid goes to INIT_PRIO.
REQ-034 SHALL be verified with a wrong-owner acknowledge: result held for requester 1 while rsp_ready_0 is high and rsp_ready_1 is low -> result stays held and no state change.
